// File: rtl/chase_pkg.sv
// ----------------------------------------------------------------------------
// chase_pkg
//   Shared definitions for the seven-LED chaser controller:
//   - state_e        : controller state (STOP, RUN, HOLD)
//   - SPD_*          : active/requested speed codes as seen on SPEED
//   - DEF_*_DIV      : default clock cycles per LED step at 100 MHz
//   - NUM_LEDS/POS_W : chaser length and position counter width
//   - pos_onehot()   : position to one-hot LED pattern
// ----------------------------------------------------------------------------
package chase_pkg;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic [1:0] SPD_STOP = 2'd0;
    localparam logic [1:0] SPD_SLOW = 2'd1;
    localparam logic [1:0] SPD_MED  = 2'd2;
    localparam logic [1:0] SPD_FAST = 2'd3;

    // Cycles per step at 100 MHz: 0.37 Hz, 1.5 Hz, 6 Hz.
    localparam int unsigned DEF_SLOW_DIV = 270_270_270;
    localparam int unsigned DEF_MED_DIV  = 66_666_667;
    localparam int unsigned DEF_FAST_DIV = 16_666_667;

    localparam int unsigned NUM_LEDS = 7;
    localparam int unsigned POS_W    = 3;

    localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);

    function automatic logic [NUM_LEDS-1:0] pos_onehot(input logic [POS_W-1:0] pos);
        logic [NUM_LEDS-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            v[i] = (32'(pos) == i);
        end
        return v;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// ----------------------------------------------------------------------------
// tick_divider
//   Free-running step counter for the chaser. Counts while enabled, wraps to
//   zero at the terminal value and flags that cycle with a one-cycle tick.
//   While disabled the count is held, so a paused period resumes where it
//   left off.
//
//   clk      in   system clock
//   rst      in   synchronous, active-high reset
//   enable   in   count this cycle
//   clear    in   force count to zero (overrides enable, suppresses tick)
//   terminal in   last count value of a period (DIV - 1)
//   tick     out  high in the cycle whose edge wraps the count
// ----------------------------------------------------------------------------
module tick_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] terminal,
    output logic             tick
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             at_term;

    always_comb begin
        at_term = (count_q == terminal);
        tick    = enable && !clear && at_term;
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = at_term ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/chase_sequencer.sv
// ----------------------------------------------------------------------------
// chase_sequencer
//   Single-clock controller for the LD9..LD15 chaser. Synchronises the speed
//   switches and pause button, resolves the speed request by priority, runs
//   the STOP/RUN/HOLD state machine and drives a registered one-hot LED
//   vector. Speed changes take effect only when a step period completes.
//
//   CLOCK     in   system clock
//   RESET     in   synchronous, active-high reset
//   SW        in   raw speed request: [2] fast, [1] medium, [0] slow
//   BTN_PAUSE in   debounced pause/resume button (rising edge = press)
//   LD        out  one-hot chaser, LD[0] = LD9 ... LD[6] = LD15
//   SPEED     out  active speed: 0 stopped, 1 slow, 2 medium, 3 fast
//   RUNNING   out  high while in RUN
//   TICK      out  one-cycle pulse coincident with each LED advance
// ----------------------------------------------------------------------------
module chase_sequencer
    import chase_pkg::*;
#(
    parameter int unsigned SLOW_DIV = DEF_SLOW_DIV,
    parameter int unsigned MED_DIV  = DEF_MED_DIV,
    parameter int unsigned FAST_DIV = DEF_FAST_DIV
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic [2:0]          SW,
    input  logic                BTN_PAUSE,
    output logic [NUM_LEDS-1:0] LD,
    output logic [1:0]          SPEED,
    output logic                RUNNING,
    output logic                TICK
);

    // Synchronisers and button edge detector
    logic [2:0] sw_meta_q,  sw_meta_d;
    logic [2:0] sw_sync_q,  sw_sync_d;
    logic       btn_meta_q, btn_meta_d;
    logic       btn_sync_q, btn_sync_d;
    logic       btn_prev_q, btn_prev_d;

    // Controller state
    state_e              state_q, state_d;
    logic [1:0]          speed_q, speed_d;
    logic [POS_W-1:0]    pos_q,   pos_d;
    logic [NUM_LEDS-1:0] ld_q,    ld_d;
    logic                tick_q,  tick_d;

    logic [1:0]  req;
    logic        pause_press;
    logic [31:0] terminal;
    logic        div_tick;
    logic        div_clear;
    logic        advance;

    always_comb begin
        sw_meta_d  = SW;
        sw_sync_d  = sw_meta_q;
        btn_meta_d = BTN_PAUSE;
        btn_sync_d = btn_meta_q;
        btn_prev_d = btn_sync_q;
    end

    assign pause_press = btn_sync_q && !btn_prev_q;

    // Highest set switch wins.
    always_comb begin
        if (sw_sync_q[2]) begin
            req = SPD_FAST;
        end else if (sw_sync_q[1]) begin
            req = SPD_MED;
        end else if (sw_sync_q[0]) begin
            req = SPD_SLOW;
        end else begin
            req = SPD_STOP;
        end
    end

    // Period follows the active speed, which only changes on a tick, so the
    // period in flight always completes at the rate it started with.
    always_comb begin
        case (speed_q)
            SPD_FAST: terminal = 32'(FAST_DIV - 1);
            SPD_MED:  terminal = 32'(MED_DIV - 1);
            default:  terminal = 32'(SLOW_DIV - 1);
        endcase
    end

    tick_divider #(
        .WIDTH (32)
    ) u_tick_divider (
        .clk      (CLOCK),
        .rst      (RESET),
        .enable   (state_q == RUN),
        .clear    (div_clear),
        .terminal (terminal),
        .tick     (div_tick)
    );

    always_comb begin
        state_d = state_q;
        speed_d = speed_q;
        pos_d   = pos_q;
        advance = 1'b0;

        case (state_q)
            STOP: begin
                // Pause presses are ignored here.
                if (req != SPD_STOP) begin
                    state_d = RUN;
                    speed_d = req;
                    pos_d   = '0;
                end
            end
            RUN: begin
                // A request of zero beats a coincident tick: no advance.
                if (req == SPD_STOP) begin
                    state_d = STOP;
                end else begin
                    if (div_tick) begin
                        advance = 1'b1;
                        speed_d = req;
                        pos_d   = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
                    end
                    if (pause_press) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (req == SPD_STOP) begin
                    state_d = STOP;
                end else if (pause_press) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = STOP;
            end
        endcase

        if (state_d == STOP) begin
            speed_d = SPD_STOP;
            pos_d   = '0;
        end

        // Count is cleared whenever the next state is STOP, which also
        // guarantees a zero count on the following STOP->RUN entry.
        div_clear = (state_d == STOP);

        // LD is computed from next-state values so it lands on the same edge
        // as pos and TICK, with no decode glitch on the wrap.
        ld_d   = (state_d == STOP) ? '0 : pos_onehot(pos_d);
        tick_d = advance;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            btn_prev_q <= 1'b0;
            state_q    <= STOP;
            speed_q    <= SPD_STOP;
            pos_q      <= '0;
            ld_q       <= '0;
            tick_q     <= 1'b0;
        end else begin
            sw_meta_q  <= sw_meta_d;
            sw_sync_q  <= sw_sync_d;
            btn_meta_q <= btn_meta_d;
            btn_sync_q <= btn_sync_d;
            btn_prev_q <= btn_prev_d;
            state_q    <= state_d;
            speed_q    <= speed_d;
            pos_q      <= pos_d;
            ld_q       <= ld_d;
            tick_q     <= tick_d;
        end
    end

    assign LD      = ld_q;
    assign SPEED   = speed_q;
    assign RUNNING = (state_q == RUN);
    assign TICK    = tick_q;

endmodule
